// File: rtl/hid_state_regs.sv
// CPU-visible register block that holds HID keyboard/mouse state for the host side.
// Shadow registers are committed to the outputs atomically; a watchdog drops devices if firmware stalls.
module hid_state_regs #(
  parameter int unsigned TIMEOUT_CYCLES = 4800000
) (
  input  logic        clk_i,
  input  logic        rstn,
  input  logic        m_sel,
  input  logic [3:0]  m_addr,
  input  logic [31:0] m_data_i,
  output logic [31:0] m_data_o,
  input  logic        m_rd,
  input  logic        m_wr,
  output logic        keyboard_connected,
  output logic        mouse_connected,
  output logic [7:0]  keyboard_modifiers,
  output logic [47:0] keyboard_keycodes,
  output logic [7:0]  mouse_buttons,
  output logic [31:0] mouse_x,
  output logic [31:0] mouse_y,
  output logic [31:0] mouse_wheel,
  output logic        kb_update,
  output logic        ms_update
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic            r_kb_conn, r_ms_conn, r_timeout;
  logic [7:0]      r_kb_mod, r_ms_btn;
  logic [47:0]     r_kb_keys;
  logic [31:0]     r_mouse_x, r_mouse_y, r_mouse_wheel;
  logic            r_kb_upd, r_ms_upd;
  logic [31:0]     r_kb_sh0, r_ms_sh;
  logic [23:0]     r_kb_sh1;
  logic [CntW-1:0] r_wdog;

  logic            w_kb_conn_d, w_ms_conn_d, w_timeout_d;
  logic [7:0]      w_kb_mod_d, w_ms_btn_d;
  logic [47:0]     w_kb_keys_d;
  logic [31:0]     w_mouse_x_d, w_mouse_y_d, w_mouse_wheel_d;
  logic            w_kb_upd_d, w_ms_upd_d;
  logic [31:0]     w_kb_sh0_d, w_ms_sh_d;
  logic [23:0]     w_kb_sh1_d;
  logic [CntW-1:0] w_wdog_d;

  logic w_wr, w_wr_ctrl;
  logic w_unused_rd;

  assign w_wr        = m_sel & m_wr;
  assign w_wr_ctrl   = w_wr & (m_addr == 4'd0);
  assign w_unused_rd = m_rd;

  always_comb begin
    w_kb_conn_d     = r_kb_conn;
    w_ms_conn_d     = r_ms_conn;
    w_timeout_d     = r_timeout;
    w_kb_mod_d      = r_kb_mod;
    w_kb_keys_d     = r_kb_keys;
    w_ms_btn_d      = r_ms_btn;
    w_mouse_x_d     = r_mouse_x;
    w_mouse_y_d     = r_mouse_y;
    w_mouse_wheel_d = r_mouse_wheel;
    w_kb_upd_d      = 1'b0;
    w_ms_upd_d      = 1'b0;
    w_kb_sh0_d      = r_kb_sh0;
    w_kb_sh1_d      = r_kb_sh1;
    w_ms_sh_d       = r_ms_sh;
    w_wdog_d        = r_wdog;

    if (w_wr && m_addr == 4'd1) w_kb_sh0_d = m_data_i;
    if (w_wr && m_addr == 4'd2) w_kb_sh1_d = m_data_i[23:0];
    if (w_wr && m_addr == 4'd3) w_ms_sh_d  = m_data_i;

    if (w_wr_ctrl) begin
      w_kb_conn_d = m_data_i[0];
      w_ms_conn_d = m_data_i[1];
      w_wdog_d    = '0;
      if (m_data_i[0] | m_data_i[1]) w_timeout_d = 1'b0;

      if (!m_data_i[0]) begin
        w_kb_mod_d  = '0;
        w_kb_keys_d = '0;
      end else if (m_data_i[8]) begin
        w_kb_mod_d  = r_kb_sh0[7:0];
        w_kb_keys_d = {r_kb_sh1, r_kb_sh0[31:8]};
        w_kb_upd_d  = 1'b1;
      end

      if (m_data_i[16]) begin
        w_mouse_x_d     = '0;
        w_mouse_y_d     = '0;
        w_mouse_wheel_d = '0;
      end

      // Clear is applied first so clear+commit leaves just the new deltas.
      if (!m_data_i[1]) begin
        w_ms_btn_d = '0;
      end else if (m_data_i[9]) begin
        w_ms_btn_d      = r_ms_sh[7:0];
        w_mouse_x_d     = w_mouse_x_d + {{24{r_ms_sh[15]}}, r_ms_sh[15:8]};
        w_mouse_y_d     = w_mouse_y_d + {{24{r_ms_sh[23]}}, r_ms_sh[23:16]};
        w_mouse_wheel_d = w_mouse_wheel_d + {{24{r_ms_sh[31]}}, r_ms_sh[31:24]};
        w_ms_upd_d      = 1'b1;
      end
    end else if (r_kb_conn | r_ms_conn) begin
      if (r_wdog == CntLast) begin
        w_kb_conn_d = 1'b0;
        w_ms_conn_d = 1'b0;
        w_kb_mod_d  = '0;
        w_kb_keys_d = '0;
        w_ms_btn_d  = '0;
        w_timeout_d = 1'b1;
        w_wdog_d    = '0;
      end else begin
        w_wdog_d = r_wdog + 1'b1;
      end
    end else begin
      w_wdog_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      r_kb_conn     <= 1'b0;
      r_ms_conn     <= 1'b0;
      r_timeout     <= 1'b0;
      r_kb_mod      <= '0;
      r_kb_keys     <= '0;
      r_ms_btn      <= '0;
      r_mouse_x     <= '0;
      r_mouse_y     <= '0;
      r_mouse_wheel <= '0;
      r_kb_upd      <= 1'b0;
      r_ms_upd      <= 1'b0;
      r_kb_sh0      <= '0;
      r_kb_sh1      <= '0;
      r_ms_sh       <= '0;
      r_wdog        <= '0;
    end else begin
      r_kb_conn     <= w_kb_conn_d;
      r_ms_conn     <= w_ms_conn_d;
      r_timeout     <= w_timeout_d;
      r_kb_mod      <= w_kb_mod_d;
      r_kb_keys     <= w_kb_keys_d;
      r_ms_btn      <= w_ms_btn_d;
      r_mouse_x     <= w_mouse_x_d;
      r_mouse_y     <= w_mouse_y_d;
      r_mouse_wheel <= w_mouse_wheel_d;
      r_kb_upd      <= w_kb_upd_d;
      r_ms_upd      <= w_ms_upd_d;
      r_kb_sh0      <= w_kb_sh0_d;
      r_kb_sh1      <= w_kb_sh1_d;
      r_ms_sh       <= w_ms_sh_d;
      r_wdog        <= w_wdog_d;
    end
  end

  always_comb begin
    m_data_o = '0;
    if (m_sel) begin
      case (m_addr)
        4'd0:    m_data_o = {28'b0, r_timeout, 1'b0, r_ms_conn, r_kb_conn};
        4'd1:    m_data_o = r_kb_sh0;
        4'd2:    m_data_o = {8'b0, r_kb_sh1};
        4'd3:    m_data_o = r_ms_sh;
        4'd4:    m_data_o = r_mouse_x;
        4'd5:    m_data_o = r_mouse_y;
        4'd6:    m_data_o = r_mouse_wheel;
        default: m_data_o = '0;
      endcase
    end
  end

  assign keyboard_connected = r_kb_conn;
  assign mouse_connected    = r_ms_conn;
  assign keyboard_modifiers = r_kb_mod;
  assign keyboard_keycodes  = r_kb_keys;
  assign mouse_buttons      = r_ms_btn;
  assign mouse_x            = r_mouse_x;
  assign mouse_y            = r_mouse_y;
  assign mouse_wheel        = r_mouse_wheel;
  assign kb_update          = r_kb_upd;
  assign ms_update          = r_ms_upd;

endmodule

// File: tb/tb_hid_state_regs.sv
// Bench for hid_state_regs: directed vector table, corner-case sequences and
// randomized traffic compared against a behavioural model of the HID register map.
module tb_hid_state_regs;

  localparam int unsigned Timeout = 16;

  logic        clk_i, rstn, m_sel, m_rd, m_wr;
  logic [3:0]  m_addr;
  logic [31:0] m_data_i, m_data_o;
  logic        keyboard_connected, mouse_connected, kb_update, ms_update;
  logic [7:0]  keyboard_modifiers, mouse_buttons;
  logic [47:0] keyboard_keycodes;
  logic [31:0] mouse_x, mouse_y, mouse_wheel;

  hid_state_regs #(.TIMEOUT_CYCLES(Timeout)) dut (
    .clk_i(clk_i), .rstn(rstn), .m_sel(m_sel), .m_addr(m_addr), .m_data_i(m_data_i),
    .m_data_o(m_data_o), .m_rd(m_rd), .m_wr(m_wr),
    .keyboard_connected(keyboard_connected), .mouse_connected(mouse_connected),
    .keyboard_modifiers(keyboard_modifiers), .keyboard_keycodes(keyboard_keycodes),
    .mouse_buttons(mouse_buttons), .mouse_x(mouse_x), .mouse_y(mouse_y),
    .mouse_wheel(mouse_wheel), .kb_update(kb_update), .ms_update(ms_update)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  logic        md_kbc, md_msc, md_sticky, md_kbu, md_msu;
  logic [7:0]  md_mod, md_btn;
  logic [7:0]  md_key[6];
  logic [31:0] md_pos[3];
  logic [31:0] md_sh[4];
  int          md_idle;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sext8(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

  function automatic logic [47:0] md_keys();
    logic [47:0] k;
    for (int i = 0; i < 6; i++) k[8*i +: 8] = md_key[i];
    return k;
  endfunction

  function automatic logic [31:0] md_read(input logic [3:0] a);
    case (a)
      4'd0:    return {28'b0, md_sticky, 1'b0, md_msc, md_kbc};
      4'd1:    return md_sh[1];
      4'd2:    return md_sh[2];
      4'd3:    return md_sh[3];
      4'd4:    return md_pos[0];
      4'd5:    return md_pos[1];
      4'd6:    return md_pos[2];
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    md_kbc = 0; md_msc = 0; md_sticky = 0; md_kbu = 0; md_msu = 0;
    md_mod = 0; md_btn = 0; md_idle = 0;
    for (int i = 0; i < 6; i++) md_key[i] = 0;
    for (int i = 0; i < 3; i++) md_pos[i] = 0;
    for (int i = 0; i < 4; i++) md_sh[i] = 0;
  endtask

  task automatic kb_clear();
    md_mod = 0;
    for (int i = 0; i < 6; i++) md_key[i] = 0;
  endtask

  task automatic model_apply(input logic we, input logic [3:0] a, input logic [31:0] d);
    md_kbu = 0; md_msu = 0;
    if (we && a == 4'd1) md_sh[1] = d;
    if (we && a == 4'd2) md_sh[2] = {8'h0, d[23:0]};
    if (we && a == 4'd3) md_sh[3] = d;
    if (we && a == 4'd0) begin
      md_kbc = d[0]; md_msc = d[1]; md_idle = 0;
      if (d[0] || d[1]) md_sticky = 0;
      if (!d[0]) kb_clear();
      else if (d[8]) begin
        md_mod = md_sh[1][7:0];
        for (int i = 0; i < 3; i++) begin
          md_key[i]     = md_sh[1][8*i+8 +: 8];
          md_key[i + 3] = md_sh[2][8*i +: 8];
        end
        md_kbu = 1;
      end
      if (d[16]) for (int i = 0; i < 3; i++) md_pos[i] = 0;
      if (!d[1]) md_btn = 0;
      else if (d[9]) begin
        md_btn = md_sh[3][7:0];
        for (int i = 0; i < 3; i++) md_pos[i] = md_pos[i] + sext8(md_sh[3][8*i+8 +: 8]);
        md_msu = 1;
      end
    end else if (md_kbc || md_msc) begin
      md_idle++;
      if (md_idle == Timeout) begin
        md_kbc = 0; md_msc = 0; md_btn = 0; md_sticky = 1; md_idle = 0;
        kb_clear();
      end
    end else begin
      md_idle = 0;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".kb_conn"}, keyboard_connected, md_kbc);
    chk({tag, ".ms_conn"}, mouse_connected, md_msc);
    chk({tag, ".mods"}, keyboard_modifiers, md_mod);
    chk({tag, ".keys"}, keyboard_keycodes, md_keys());
    chk({tag, ".buttons"}, mouse_buttons, md_btn);
    chk({tag, ".mouse_x"}, mouse_x, md_pos[0]);
    chk({tag, ".mouse_y"}, mouse_y, md_pos[1]);
    chk({tag, ".wheel"}, mouse_wheel, md_pos[2]);
    chk({tag, ".kb_update"}, kb_update, md_kbu);
    chk({tag, ".ms_update"}, ms_update, md_msu);
  endtask

  // Combinational read; called between the sampling point and the next negedge.
  task automatic check_read(input string tag, input logic [3:0] a);
    m_sel = 1; m_rd = 1; m_wr = 0; m_addr = a;
    #1;
    chk({tag, ".read"}, m_data_o, md_read(a));
    m_sel = 0; m_rd = 0;
  endtask

  task automatic step(input logic sel, input logic wr, input logic [3:0] a,
                      input logic [31:0] d);
    @(negedge clk_i);
    m_sel = sel; m_wr = wr; m_addr = a; m_data_i = d; m_rd = 0;
    @(posedge clk_i);
    model_apply(sel & wr, a, d);
    #1;
    m_sel = 0; m_wr = 0;
  endtask

  typedef struct {
    logic [3:0]  a;
    logic [31:0] d;
    logic        kbc, msc;
    logic [7:0]  mods;
    logic [47:0] keys;
    logic [7:0]  btn;
    logic [31:0] x, y, w;
    logic        kbu, msu;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{4'h1, 32'h06050402, 0, 0, 8'h00, 48'h0, 8'h00, 32'h0, 32'h0, 32'h0, 0, 0};
    tbl[1] = '{4'h2, 32'h00090807, 0, 0, 8'h00, 48'h0, 8'h00, 32'h0, 32'h0, 32'h0, 0, 0};
    tbl[2] = '{4'h0, 32'h00000100, 0, 0, 8'h00, 48'h0, 8'h00, 32'h0, 32'h0, 32'h0, 0, 0};
    tbl[3] = '{4'h0, 32'h00000101, 1, 0, 8'h02, 48'h090807060504, 8'h00,
               32'h0, 32'h0, 32'h0, 1, 0};
    tbl[4] = '{4'hF, 32'h00000000, 1, 0, 8'h02, 48'h090807060504, 8'h00,
               32'h0, 32'h0, 32'h0, 0, 0};
    tbl[5] = '{4'h3, 32'hFF02FD01, 1, 0, 8'h02, 48'h090807060504, 8'h00,
               32'h0, 32'h0, 32'h0, 0, 0};
    tbl[6] = '{4'h0, 32'h00000203, 1, 1, 8'h02, 48'h090807060504, 8'h01,
               32'hFFFFFFFD, 32'h2, 32'hFFFFFFFF, 0, 1};
    tbl[7] = '{4'h0, 32'h00000203, 1, 1, 8'h02, 48'h090807060504, 8'h01,
               32'hFFFFFFFA, 32'h4, 32'hFFFFFFFE, 0, 1};
    tbl[8] = '{4'hF, 32'h00000000, 1, 1, 8'h02, 48'h090807060504, 8'h01,
               32'hFFFFFFFA, 32'h4, 32'hFFFFFFFE, 0, 0};
    tbl[9] = '{4'h0, 32'h00000001, 1, 0, 8'h02, 48'h090807060504, 8'h00,
               32'hFFFFFFFA, 32'h4, 32'hFFFFFFFE, 0, 0};

    rstn = 0; m_sel = 0; m_rd = 0; m_wr = 0; m_addr = 0; m_data_i = 0;
    model_reset();
    #3;
    check_model("reset");
    check_read("reset.status", 4'd0);
    #8 rstn = 1;

    // Directed vector table
    foreach (tbl[i]) begin
      string t;
      t = $sformatf("vec%0d", i);
      step(1, 1, tbl[i].a, tbl[i].d);
      chk({t, ".kb_conn"}, keyboard_connected, tbl[i].kbc);
      chk({t, ".ms_conn"}, mouse_connected, tbl[i].msc);
      chk({t, ".mods"}, keyboard_modifiers, tbl[i].mods);
      chk({t, ".keys"}, keyboard_keycodes, tbl[i].keys);
      chk({t, ".buttons"}, mouse_buttons, tbl[i].btn);
      chk({t, ".mouse_x"}, mouse_x, tbl[i].x);
      chk({t, ".mouse_y"}, mouse_y, tbl[i].y);
      chk({t, ".wheel"}, mouse_wheel, tbl[i].w);
      chk({t, ".kb_update"}, kb_update, tbl[i].kbu);
      chk({t, ".ms_update"}, ms_update, tbl[i].msu);
    end
    check_read("tbl.kb0", 4'd1);
    check_read("tbl.kb1", 4'd2);

    // Signed wrap at the 32-bit boundary, then clear combined with commit
    step(1, 1, 4'd3, 32'h00000100);
    force dut.r_mouse_x = 32'h7FFFFFFF;
    #1;
    release dut.r_mouse_x;
    md_pos[0] = 32'h7FFFFFFF;
    step(1, 1, 4'd0, 32'h00000202);
    chk("wrap.mouse_x", mouse_x, 32'h80000000);
    check_model("wrap");
    step(1, 1, 4'd3, 32'h00000300);
    step(1, 1, 4'd0, 32'h00010202);
    chk("clr_commit.mouse_x", mouse_x, 32'h3);
    chk("clr_commit.mouse_y", mouse_y, 32'h0);
    chk("clr_commit.wheel", mouse_wheel, 32'h0);
    check_model("clr_commit");

    // Watchdog expiry after Timeout idle cycles
    step(1, 1, 4'd1, 32'h44332211);
    step(1, 1, 4'd0, 32'h00000303);
    for (int i = 0; i < Timeout - 1; i++) begin
      step(0, 0, 4'd0, 32'h0);
      check_model($sformatf("wd_idle%0d", i));
    end
    step(0, 0, 4'd0, 32'h0);
    chk("wd.kb_conn", keyboard_connected, 1'b0);
    chk("wd.ms_conn", mouse_connected, 1'b0);
    chk("wd.keys", keyboard_keycodes, 48'h0);
    chk("wd.buttons", mouse_buttons, 8'h0);
    m_sel = 1; m_addr = 0;
    #1 chk("wd.status", m_data_o, 32'h8);
    m_sel = 0;
    check_model("wd");

    // CTRL write landing on the would-be timeout cycle wins
    step(1, 1, 4'd0, 32'h00000003);
    for (int i = 0; i < Timeout - 1; i++) step(0, 0, 4'd0, 32'h0);
    step(1, 1, 4'd0, 32'h00000003);
    chk("wd_prio.kb_conn", keyboard_connected, 1'b1);
    check_read("wd_prio.status", 4'd0);
    for (int i = 0; i < Timeout; i++) begin
      step(0, 0, 4'd0, 32'h0);
      check_model($sformatf("wd_prio%0d", i));
    end

    // Reset asserted across a commit edge: commit lost, no pulse
    step(1, 1, 4'd0, 32'h00000103);
    @(negedge clk_i);
    m_sel = 1; m_wr = 1; m_addr = 0; m_data_i = 32'h00000303;
    #2 rstn = 0;
    @(posedge clk_i);
    #1 m_sel = 0; m_wr = 0;
    model_reset();
    check_model("rst_commit");
    #1 rstn = 1;

    // Short asynchronous reset pulse with no clock edge
    step(1, 1, 4'd3, 32'h05050507);
    step(1, 1, 4'd0, 32'h00000203);
    #1 rstn = 0;
    #1;
    model_reset();
    check_model("async_rst");
    rstn = 1;

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [3:0]  a;
      logic [31:0] d;
      logic        s, w;
      a = 4'($urandom_range(0, 7));
      d = $urandom;
      s = ($urandom_range(0, 3) != 0);
      w = ($urandom_range(0, 1) != 0);
      step(s, w, a, d);
      check_model("rnd");
      check_read("rnd", 4'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hid_state_regs.md
HID_STATE_REGS -- requirements
Module: hid_state_regs

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 4800000, meaning the host-firmware watchdog period in clk_i cycles (100 ms at 48 MHz).
REQ-002 SHALL have port clk_i  input  1  the single clock, 48 MHz.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port m_sel  input  1  CPU bus select (base 0x220000xx, decoded outside).
REQ-005 SHALL have port m_addr  input  4  word index.
REQ-006 SHALL have port m_data_i  input  32  write data.
REQ-007 SHALL have port m_data_o  output  32  read data.
REQ-008 SHALL have port m_rd  input  1  read strobe.
REQ-009 SHALL have port m_wr  input  1  write strobe.
REQ-010 SHALL have outputs keyboard_connected and mouse_connected, each 1 bit: device present.
REQ-011 SHALL have outputs keyboard_modifiers (8 bits) and keyboard_keycodes (48 bits): keycodes are key0 in bits [7:0] through key5 in bits [47:40].
REQ-012 SHALL have output mouse_buttons (8 bits): mouse button state.
REQ-013 SHALL have outputs mouse_x, mouse_y and mouse_wheel, each 32 bits signed: accumulated position.
REQ-014 SHALL have outputs kb_update and ms_update, each 1 bit: one-cycle pulse on each committed report.

Function
REQ-015 SHALL apply a write only in a cycle where m_sel & m_wr is true; one write per cycle.
REQ-016 SHALL implement CTRL at address 0 (write): bit0 KB_CONN, bit1 MS_CONN, bit8 KB_COMMIT, bit9 MS_COMMIT, bit16 MS_CLEAR.
REQ-017 SHALL implement KB0 at address 1 (write): writes shadow {key2, key1, key0, modifiers} from [31:0].
REQ-018 SHALL implement KB1 at address 2 (write): writes shadow {key5, key4, key3} from [23:0].
REQ-019 SHALL implement MS at address 3 (write): writes shadow {wheel_d, dy, dx, buttons} from [31:0]; dx, dy and wheel_d are signed 8-bit.
REQ-020 SHALL implement address 0 read as STATUS: {28'b0, timeout_sticky, 1'b0, mouse_connected, keyboard_connected}.
REQ-021 SHALL return mouse_x, mouse_y and mouse_wheel on reads of addresses 4, 5 and 6 respectively.
REQ-022 SHALL return the shadow words on reads of addresses 1-3; other addresses read 0.
REQ-023 SHALL drive m_data_o combinationally from m_sel and m_addr, and drive 0 when m_sel=0; reads have no side effects.
REQ-024 SHALL update both *_connected outputs from CTRL bits 0 and 1 on every CTRL write, at the next clk_i edge.
REQ-025 SHALL zero keyboard_modifiers and keyboard_keycodes in that same cycle whenever keyboard_connected goes 0; same for mouse_buttons when mouse_connected goes 0; positions are held.
REQ-026 SHALL, on KB_COMMIT with KB_CONN=1 in the same write, copy the shadow to the keyboard outputs at the next edge, and assert kb_update for exactly that one cycle.
REQ-027 SHALL, on MS_COMMIT with MS_CONN=1, at the next edge set mouse_buttons to the shadow buttons, add the sign-extended dx/dy/wheel_d to mouse_x/y/wheel, and pulse ms_update.
REQ-028 SHALL ignore a commit written with its CONN bit 0; no output change and no pulse.
REQ-029 SHALL wrap the accumulation modulo 2^32 with no saturation (0x7FFFFFFF + 1 -> 0x80000000).
REQ-030 SHALL, on MS_CLEAR, zero mouse_x/y/wheel; MS_CLEAR with MS_COMMIT in the same write yields positions equal to the sign-extended deltas.
REQ-031 SHALL take commit data from the shadow value present before the commit edge.
REQ-032 SHALL run a watchdog counter that restarts at 0 on every CTRL write and otherwise increments while either *_connected=1.
REQ-033 SHALL, when the watchdog reaches TIMEOUT_CYCLES-1, at the next edge clear both *_connected, apply REQ-025, set timeout_sticky and restart the counter.
REQ-034 SHALL, when a CTRL write coincides with the timeout cycle, give the CTRL write priority (no timeout).
REQ-035 SHALL clear timeout_sticky on any CTRL write with bit0 or bit1 set.
REQ-036 SHALL hold the counter at 0 while both *_connected=0.

Reset
REQ-037 SHALL, while rstn=0, asynchronously force all outputs, shadows, the counter and timeout_sticky to 0.
REQ-038 SHALL, on deassertion of rstn, resume at the first clk_i edge; a commit in progress is lost, with no pulse.

Verification
REQ-039 SHALL cover: reset, then write KB0=0x06050402, KB1=0x00090807 and CTRL=0x101 -> next cycle modifiers=0x02, keycodes=0x090807060504, kb_update high 1 cycle.
REQ-040 SHALL cover: write MS=0xFF02FD01 and CTRL=0x202 twice -> buttons=0x01, mouse_x=-6, mouse_y=4, mouse_wheel=-2, two ms_update pulses.
REQ-041 SHALL cover: preload mouse_x=0x7FFFFFFF, commit dx=+1 -> 0x80000000; then CTRL=0x10202 with dx=3 -> mouse_x=3.
REQ-042 SHALL cover: TIMEOUT_CYCLES=16, connect both, then idle -> after 16 cycles connected=0, keys/buttons=0, STATUS=0x8; a CTRL write on cycle 15 -> no timeout.
REQ-043 SHALL cover: CTRL=0x100 (commit, KB_CONN=0) -> keyboard outputs unchanged, no kb_update.
REQ-044 SHALL cover: rstn low for 1 ns mid-operation without a clock edge -> all outputs 0 immediately.
